data_memory_pipelined: RTL

//   Byte-addressable, parametrised data memory for the CPU MEM stage; successor of the single-cycle

---
 rtl/dmem_pkg.sv | 50 +++++
 rtl/dmem_align.sv | 38 +++
 rtl/data_memory_pipelined.sv | 111 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the pipelined data memory.
//   SZ_*          access size codes carried in req_width[1:0]
//   ZEXT_BIT      req_width bit selecting zero-extension on loads
//   pipe_stage_t  one response-pipe stage {valid, is_st, fault, rdata}
//   lane_strobe   byte-lane write mask for a size at a byte offset
//   is_misaligned natural-alignment test for a size at a byte offset
package dmem_pkg;

  localparam int WORD_BITS = 64;
  localparam int LANES     = 8;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam int ZEXT_BIT = 2;

  typedef struct packed {
    logic                 valid;
    logic                 is_st;
    logic                 fault;
    logic [WORD_BITS-1:0] rdata;
  } pipe_stage_t;

  function automatic logic [LANES-1:0] lane_strobe(input logic [1:0] size,
                                                   input logic [2:0] off);
    logic [LANES-1:0] base;
    unique case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [2:0] off);
    logic mis;
    unique case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      SZ_W:    mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane alignment for the data memory.
//   size, zext, off  access size, zero-extend flag, byte offset in the word
//   wdata            right-justified store data
//   word             64-bit word currently held at the addressed index
//   wdata_shifted    store data moved onto its byte lanes
//   strobe           byte lanes the store may write
//   rdata            load field extracted from word and sign/zero extended
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]           size,
  input  logic                 zext,
  input  logic [2:0]           off,
  input  logic [WORD_BITS-1:0] wdata,
  input  logic [WORD_BITS-1:0] word,
  output logic [WORD_BITS-1:0] wdata_shifted,
  output logic [LANES-1:0]     strobe,
  output logic [WORD_BITS-1:0] rdata
);

  logic [WORD_BITS-1:0] field;

  // NOTE: every output of a combinational block gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    wdata_shifted = wdata << {off, 3'b000};
    strobe        = lane_strobe(size, off);
    field         = word >> {off, 3'b000};
    rdata         = field;
    unique case (size)
      SZ_B: rdata = zext ? {56'd0, field[7:0]}  : {{56{field[7]}},  field[7:0]};
      SZ_H: rdata = zext ? {48'd0, field[15:0]} : {{48{field[15]}}, field[15:0]};
      SZ_W: rdata = zext ? {32'd0, field[31:0]} : {{32{field[31]}}, field[31:0]};
      default: rdata = field;
    endcase
  end

endmodule

// File: rtl/data_memory_pipelined.sv
// Byte-addressable data memory for the MEM stage with valid/ready request and
// response handshakes and a READ_LATENCY-deep response pipe.
//   clk, rst                  clock; synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_we, req_width         store flag; [1:0] size, [2] zero-extend loads
//   req_addr, req_wdata       byte address; right-justified store data
//   resp_valid/resp_ready     response handshake
//   resp_rdata, resp_fault    extended load data (0 for stores/faults); fault flag
//   resp_is_st                response belongs to a store
module data_memory_pipelined
  import dmem_pkg::*;
#(
  parameter int    DATA_WIDTH   = 64,
  parameter int    DEPTH        = 32,
  parameter int    ADDR_WIDTH   = 8,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_width,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_fault,
  output logic                  resp_is_st
);

  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] MEM_BYTES = 64'(DEPTH) * 64'd8;

  // NOTE: the array has no reset; contents survive rst and start undefined.
  logic [WORD_BITS-1:0] mem [DEPTH];

  logic [IDX_W-1:0]     word_idx;
  logic [WORD_BITS-1:0] rd_word;
  logic [WORD_BITS-1:0] wdata_shifted;
  logic [LANES-1:0]     strobe;
  logic [WORD_BITS-1:0] ld_data;
  logic                 fault;
  logic                 stall;
  logic                 accept;
  pipe_stage_t          new_stage;
  pipe_stage_t          stg [READ_LATENCY];

  assign word_idx = req_addr[IDX_W+2:3];
  // Faulting addresses may index past the array; that read is discarded.
  assign rd_word  = mem[word_idx];

  dmem_align u_align (
    .size          (req_width[1:0]),
    .zext          (req_width[ZEXT_BIT]),
    .off           (req_addr[2:0]),
    .wdata         (req_wdata[WORD_BITS-1:0]),
    .word          (rd_word),
    .wdata_shifted (wdata_shifted),
    .strobe        (strobe),
    .rdata         (ld_data)
  );

  assign fault = is_misaligned(req_width[1:0], req_addr[2:0])
               || (64'(req_addr) >= MEM_BYTES);

  // The whole pipe freezes when the oldest response is not taken; no bubble
  // squeezing keeps every stage's contents stable under backpressure.
  assign stall     = stg[READ_LATENCY-1].valid && !resp_ready;
  assign req_ready = !rst && !stall;
  assign accept    = req_valid && req_ready;

  always_comb begin
    new_stage = '0;
    if (accept) begin
      new_stage.valid = 1'b1;
      new_stage.is_st = req_we;
      new_stage.fault = fault;
      new_stage.rdata = (req_we || fault) ? '0 : ld_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) stg[i] <= '0;
    end else if (!stall) begin
      stg[0] <= new_stage;
      for (int i = 1; i < READ_LATENCY; i++) stg[i] <= stg[i-1];
    end
  end

  // Stores land at the accept edge, so a load accepted the next cycle reads
  // the updated word straight from the array.
  always_ff @(posedge clk) begin
    if (accept && req_we && !fault) begin
      for (int l = 0; l < LANES; l++) begin
        if (strobe[l]) mem[word_idx][8*l +: 8] <= wdata_shifted[8*l +: 8];
      end
    end
  end

  assign resp_valid = stg[READ_LATENCY-1].valid;
  assign resp_fault = stg[READ_LATENCY-1].fault;
  assign resp_is_st = stg[READ_LATENCY-1].is_st;
  assign resp_rdata = DATA_WIDTH'(stg[READ_LATENCY-1].rdata);

endmodule
